// File: rtl/jt1943_prog_loader_pkg.sv
// Shared definitions for the 1943 download path: FSM encoding, default region
// bases and the layout of one buffered SDRAM write.
package jt1943_loader_defs;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [24:0] PROM_START_DEF = 25'h5_8000;
    localparam int          PROM_NUM_DEF   = 8;
    localparam int          FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic        odd;
    } prog_entry_t;

    // SDRAM mask bits are "do not write": even bytes go to the low lane.
    function automatic logic [1:0] lane_mask(input logic odd);
        return odd ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/jt1943_prog_fifo.sv
// Small synchronous FIFO for pending SDRAM writes; the head entry is the one
// currently offered to the SDRAM controller.
module jt1943_prog_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/jt1943_prog_loader.sv
// Download stage: steers ioctl bytes to the SDRAM write FIFO or to the colour
// PROMs and keeps the core in reset until everything has been committed.
module jt1943_prog_loader
    import jt1943_loader_defs::*;
#(
    parameter logic [24:0] PROM_START = PROM_START_DEF,
    parameter int          PROM_NUM   = PROM_NUM_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic                ioctl_wait,
    output logic                prog_we,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    input  logic                prog_ack,
    output logic [PROM_NUM-1:0] prom_we,
    output logic [7:0]          prom_addr,
    output logic [7:0]          prom_data,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              SW       = $clog2(PROM_NUM);
    localparam logic [24:0]     ROM_END  = PROM_START + 25'(PROM_NUM * 256);
    localparam logic [CW-1:0]   WAIT_LVL = CW'(FIFO_DEPTH - 1);

    logic [1:0]          state;
    logic                wr_ok, sdram_hit, prom_hit, oor, push, pop, overflow;
    logic                full, empty;
    logic [CW-1:0]       count, count_nxt;
    logic [SW+7:0]       off;
    logic [PROM_NUM-1:0] prom_sel;
    prog_entry_t         din, head;

    assign wr_ok     = ioctl_wr && (state == ST_LOAD);
    assign sdram_hit = ioctl_addr < PROM_START;
    assign prom_hit  = !sdram_hit && (ioctl_addr < ROM_END);
    assign off       = (SW+8)'(ioctl_addr - PROM_START);

    // A pop in the same cycle frees the slot, so a push on a full FIFO is fine then.
    assign pop       = prog_we && prog_ack;
    assign push      = wr_ok && sdram_hit && (!full || pop);
    assign overflow  = wr_ok && sdram_hit && full && !pop;
    assign oor       = wr_ok && !sdram_hit && !prom_hit;
    assign count_nxt = count + CW'(push) - CW'(pop);

    assign din = '{addr: ioctl_addr[22:1], data: ioctl_data, odd: ioctl_addr[0]};

    always_comb begin
        prom_sel = '0;
        if (wr_ok && prom_hit) prom_sel[off[8 +: SW]] = 1'b1;
    end

    jt1943_prog_fifo #(
        .W     ($bits(prog_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prog_we    <= 1'b0;
            prom_we    <= '0;
            prom_addr  <= '0;
            prom_data  <= '0;
            ioctl_wait <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            prom_we <= prom_sel;
            if (wr_ok && prom_hit) begin
                prom_addr <= off[7:0];
                prom_data <= ioctl_data;
            end
            ioctl_wait <= count_nxt >= WAIT_LVL;

            // Request stays up across an ack while anything is left behind it.
            if (!prog_we)
                prog_we <= !empty;
            else if (prog_ack)
                prog_we <= count_nxt != '0;

            case (state)
                ST_IDLE: if (downloading) begin
                    state    <= ST_LOAD;
                    load_err <= 1'b0;
                end
                ST_LOAD: if (!downloading) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (downloading)
                        state <= ST_LOAD;
                    else if (empty && !prog_we)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase

            if (oor || overflow) load_err <= 1'b1;
        end
    end

    assign prog_addr = prog_we ? head.addr : '0;
    assign prog_data = prog_we ? head.data : '0;
    assign prog_mask = prog_we ? lane_mask(head.odd) : '0;
    assign load_busy = (state == ST_LOAD) || (state == ST_DRAIN);
    assign load_done = state == ST_DONE;

endmodule

// File: tb/tb_jt1943_prog_loader.sv
// Scoreboard bench for the download stage: expected SDRAM writes are queued as
// bytes are driven and retired when the DUT sees an ack.
module tb_jt1943_prog_loader;

    localparam logic [24:0] PS = 25'h5_8000;
    localparam logic [24:0] RE = 25'h5_8800;

    logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0, prog_ack = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wait, prog_we, load_busy, load_done, load_err;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data, prom_addr, prom_data;
    logic [1:0]  prog_mask;
    logic [7:0]  prom_we;

    int checks = 0, failures = 0;
    int we_cycles = 0, wr_count = 0, prom_pulses = 0;
    int w0, p0, done_cnt;
    logic busy_bad, done_busy, seen;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    jt1943_prog_loader dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_ack(prog_ack), .prom_we(prom_we),
        .prom_addr(prom_addr), .prom_data(prom_data), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_w(input logic [24:0] a, input logic [7:0] d);
        return {a[22:1], d, (a[0] ? 2'b01 : 2'b10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic sdram_byte(input logic [24:0] a, input logic [7:0] d);
        sb_q.push_back(exp_w(a, d));
        wr_byte(a, d);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prog_we) we_cycles++;
            if (|prom_we) prom_pulses++;
            if (prog_we && prog_ack) begin
                wr_count++;
                if (sb_q.size() == 0)
                    chk("sb_unexpected_write", {prog_addr, prog_data, prog_mask}, 32'hFFFF_FFFF);
                else
                    chk("sb_write", {prog_addr, prog_data, prog_mask}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #22;
        chk("rst_prog_we",    32'(prog_we), 0);
        chk("rst_prog_mask",  32'(prog_mask), 0);
        chk("rst_prom_we",    32'(prom_we), 0);
        chk("rst_ioctl_wait", 32'(ioctl_wait), 0);
        chk("rst_busy",       32'(load_busy), 0);
        chk("rst_done",       32'(load_done), 0);
        chk("rst_err",        32'(load_err), 0);
        tick();
        rst_n = 1'b1;
        downloading = 1'b1;
        tick(); tick();
        chk("t1_busy", 32'(load_busy), 1);

        // even/odd byte pair with ack tied high
        prog_ack = 1'b1;
        w0 = we_cycles;
        sdram_byte(25'h0, 8'hAA);
        sdram_byte(25'h1, 8'h55);
        repeat (5) tick();
        chk("t1_we_cycles", 32'(we_cycles - w0), 2);
        chk("t1_sb_empty",  32'(sb_q.size()), 0);
        sdram_byte(PS - 25'd1, 8'h11);
        repeat (4) tick();
        chk("t1_last_sdram", 32'(sb_q.size()), 0);

        // PROM routing, including the final PROM byte
        p0 = prom_pulses; w0 = we_cycles;
        wr_byte(PS + 25'h1FF, 8'h3C);
        chk("t2_prom_we",   32'(prom_we), 32'h02);
        chk("t2_prom_addr", 32'(prom_addr), 32'hFF);
        chk("t2_prom_data", 32'(prom_data), 32'h3C);
        tick();
        chk("t2_prom_we_clr", 32'(prom_we), 0);
        wr_byte(RE - 25'd1, 8'h5A);
        chk("t2_prom_last",      32'(prom_we), 32'h80);
        chk("t2_prom_last_addr", 32'(prom_addr), 32'hFF);
        tick();
        chk("t2_prom_pulses", 32'(prom_pulses - p0), 2);
        chk("t2_no_sdram",    32'(we_cycles - w0), 0);

        // back-pressure and overflow with ack held low
        prog_ack = 1'b0;
        w0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            sdram_byte(25'h100 + 25'(i), 8'hC0 + 8'(i));
            if (i == 1) chk("t3_wait_lo", 32'(ioctl_wait), 0);
        end
        tick();
        chk("t3_wait", 32'(ioctl_wait), 1);
        chk("t3_err_lo", 32'(load_err), 0);
        sdram_byte(25'h103, 8'hC3);
        wr_byte(25'h104, 8'hC4);
        tick();
        chk("t3_err", 32'(load_err), 1);
        prog_ack = 1'b1;
        repeat (10) tick();
        prog_ack = 1'b0;
        chk("t3_writes",   32'(wr_count - w0), 4);
        chk("t3_sb_empty", 32'(sb_q.size()), 0);
        chk("t3_wait_clr", 32'(ioctl_wait), 0);

        // drain after downloading falls, ack every 4th cycle
        for (int i = 0; i < 3; i++) sdram_byte(25'h200 + 25'(i), 8'hD0 + 8'(i));
        downloading = 1'b0;
        busy_bad = 1'b0;
        for (int c = 0; c < 80 && sb_q.size() != 0; c++) begin
            prog_ack = (c % 4 == 3);
            if (!load_busy) busy_bad = 1'b1;
            tick();
        end
        prog_ack = 1'b0;
        chk("t4_drained",   32'(sb_q.size()), 0);
        chk("t4_busy_held", 32'(busy_bad), 0);
        done_cnt = 0; done_busy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (load_done) begin
                done_cnt++;
                if (load_busy) done_busy = 1'b1;
            end
            tick();
        end
        chk("t4_done_pulses", 32'(done_cnt), 1);
        chk("t4_done_busy",   32'(done_busy), 0);
        chk("t4_idle_busy",   32'(load_busy), 0);

        // out-of-range byte, then a fresh download clears the error
        downloading = 1'b1;
        tick(); tick();
        chk("t5_err_cleared", 32'(load_err), 0);
        p0 = prom_pulses; w0 = we_cycles;
        wr_byte(RE, 8'h77);
        tick(); tick();
        chk("t5_err",     32'(load_err), 1);
        chk("t5_no_prom", 32'(prom_pulses - p0), 0);
        chk("t5_no_prog", 32'(we_cycles - w0), 0);
        downloading = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (load_done) seen = 1'b1;
            tick();
        end
        chk("t5_done_seen", 32'(seen), 1);
        downloading = 1'b1;
        tick(); tick();
        chk("t5_err_new_dl", 32'(load_err), 0);

        // reset in the middle of a download with a request pending
        sdram_byte(25'h300, 8'hE0);
        sdram_byte(25'h301, 8'hE1);
        tick();
        chk("t6_pending", 32'(prog_we), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_prog_we", 32'(prog_we), 0);
        chk("t6_rst_mask",    32'(prog_mask), 0);
        chk("t6_rst_busy",    32'(load_busy), 0);
        sb_q.delete();
        w0 = we_cycles;
        tick();
        rst_n = 1'b1;
        prog_ack = 1'b1;
        repeat (6) tick();
        chk("t6_reload",   32'(load_busy), 1);
        chk("t6_no_stale", 32'(we_cycles - w0), 0);

        downloading = 1'b0;
        repeat (6) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
